// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of any depth with registered or
// first-word-fall-through read, threshold flags and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_cs,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_cs,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_nxt;

  assign wr_ok = wr_cs & wr_en & ~full;
  assign rd_ok = rd_cs & rd_en & ~empty;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= (AE_THRESH >= 0);
      almost_full  <= (AF_THRESH <= 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      overflow     <= (wr_cs & wr_en & full) | (overflow & ~clr_err);
      underflow    <= (rd_cs & rd_en & empty) | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown combinationally; zero while nothing is stored.
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else if (rd_ok) rd_q <= mem[rd_ptr];
      end
      assign data_out = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench over three FIFO configurations.
// Expected words are queued on accepted writes and popped on reads.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: DEPTH 8, registered read, AF 6, AE 2
  logic       a_rst = 1'b1, a_wr_cs = 1'b0, a_wr_en = 1'b0;
  logic       a_rd_cs = 1'b0, a_rd_en = 1'b0, a_clr = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [3:0] a_cnt;

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1'b0),
                    .AF_THRESH(6), .AE_THRESH(2)) u_a (
    .clk(clk), .rst(a_rst), .wr_cs(a_wr_cs), .wr_en(a_wr_en),
    .data_in(a_din), .rd_cs(a_rd_cs), .rd_en(a_rd_en),
    .data_out(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr)
  );

  // Instance B: DEPTH 6, registered read
  logic       b_rst = 1'b1, b_wr_cs = 1'b0, b_wr_en = 1'b0;
  logic       b_rd_cs = 1'b0, b_rd_en = 1'b0, b_clr = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [2:0] b_cnt;

  sync_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .wr_cs(b_wr_cs), .wr_en(b_wr_en),
    .data_in(b_din), .rd_cs(b_rd_cs), .rd_en(b_rd_en),
    .data_out(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr)
  );

  // Instance C: DEPTH 4, first-word-fall-through
  logic       c_rst = 1'b1, c_wr_cs = 1'b0, c_wr_en = 1'b0;
  logic       c_rd_cs = 1'b0, c_rd_en = 1'b0, c_clr = 1'b0;
  logic [7:0] c_din = '0, c_dout;
  logic       c_empty, c_full, c_ae, c_af, c_ovf, c_udf;
  logic [2:0] c_cnt;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .wr_cs(c_wr_cs), .wr_en(c_wr_en),
    .data_in(c_din), .rd_cs(c_rd_cs), .rd_en(c_rd_en),
    .data_out(c_dout), .empty(c_empty), .full(c_full),
    .almost_empty(c_ae), .almost_full(c_af), .count(c_cnt),
    .overflow(c_ovf), .underflow(c_udf), .clr_err(c_clr)
  );

  logic [7:0] q[$];
  logic [7:0] exp_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_cs = 0; a_wr_en = 0; a_rd_cs = 0; a_rd_en = 0; a_clr = 0;
  endtask

  task automatic a_reset();
    a_idle();
    a_rst = 1; step(); a_rst = 0;
    q.delete();
  endtask

  task automatic a_write(input logic [7:0] d);
    a_idle();
    a_wr_cs = 1; a_wr_en = 1; a_din = d;
    step();
    q.push_back(d);
    a_idle();
  endtask

  task automatic a_read(input string tag);
    a_idle();
    a_rd_cs = 1; a_rd_en = 1;
    step();
    a_idle();
    exp_d = q.pop_front();
    n_cmp++;
    if (a_dout !== exp_d) begin
      n_err++;
      $display("FAIL %s data got %h want %h", tag, a_dout, exp_d);
    end
  endtask

  task automatic test_reset();
    a_reset();
    n_cmp++;
    if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) begin
      n_err++;
      $display("FAIL rst_flags got %b want 1010",
               {a_empty, a_full, a_ae, a_af});
    end
    n_cmp++;
    if (a_cnt !== 4'd0 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin
      n_err++;
      $display("FAIL rst_cnt_err got %0d/%b/%b want 0/0/0",
               a_cnt, a_ovf, a_udf);
    end
    n_cmp++;
    if (a_dout !== 8'h00) begin
      n_err++;
      $display("FAIL rst_dout got %h want 00", a_dout);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) a_write(8'(i));
    n_cmp++;
    if (a_full !== 1'b1 || a_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL t1_full got %b/%0d want 1/8", a_full, a_cnt);
    end
    for (int i = 0; i < 8; i++) a_read("t1_read");
    n_cmp++;
    if (a_empty !== 1'b1 || a_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL t1_empty got %b/%0d want 1/0", a_empty, a_cnt);
    end
  endtask

  task automatic test_errors();
    logic [7:0] hold;
    for (int i = 0; i < 8; i++) a_write(8'(8'h11 + i));
    a_idle();
    a_wr_cs = 1; a_wr_en = 1; a_din = 8'hAA;
    step();
    a_idle();
    n_cmp++;
    if (a_ovf !== 1'b1 || a_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL t2_ovf got %b/%0d want 1/8", a_ovf, a_cnt);
    end
    a_clr = 1; step(); a_idle();
    n_cmp++;
    if (a_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL t2_clr got %b want 0", a_ovf);
    end
    for (int i = 0; i < 8; i++) a_read("t2_read");
    hold = a_dout;
    // underflow set and clear in one cycle: set wins
    a_rd_cs = 1; a_rd_en = 1; a_clr = 1;
    step();
    a_idle();
    n_cmp++;
    if (a_udf !== 1'b1 || a_dout !== hold || a_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL t2_udf got %b/%h/%0d want 1/%h/0",
               a_udf, a_dout, a_cnt, hold);
    end
    a_clr = 1; step(); a_idle();
    n_cmp++;
    if (a_udf !== 1'b0) begin
      n_err++;
      $display("FAIL t2_udf_clr got %b want 0", a_udf);
    end
  endtask

  task automatic b_cycle(input bit w, input bit r, input logic [7:0] d);
    int mc;
    bit wa, ra;
    mc = int'(q.size());
    wa = w && (mc < 6);
    ra = r && (mc > 0);
    b_wr_cs = w; b_wr_en = w; b_din = d;
    b_rd_cs = r; b_rd_en = r;
    step();
    b_wr_cs = 0; b_wr_en = 0; b_rd_cs = 0; b_rd_en = 0;
    if (ra) exp_d = q.pop_front();
    if (wa) q.push_back(d);
    n_cmp++;
    if (int'(b_cnt) !== int'(q.size())) begin
      n_err++;
      $display("FAIL t3_count got %0d want %0d", b_cnt, q.size());
    end
    if (ra) begin
      n_cmp++;
      if (b_dout !== exp_d) begin
        n_err++;
        $display("FAIL t3_data got %h want %h", b_dout, exp_d);
      end
    end
  endtask

  task automatic test_wrap_npot();
    logic [7:0] pat;
    q.delete();
    b_rst = 1; step(); b_rst = 0;
    pat = 8'h40;
    b_cycle(1, 0, pat); pat++;
    b_cycle(1, 0, pat); pat++;
    for (int i = 0; i < 20; i++) begin
      b_cycle(1, 0, pat); pat++;
      b_cycle(1, 1, pat); pat++;
      if (i % 4 == 3) begin
        b_cycle(1, 0, pat); pat++;
        b_cycle(1, 0, pat); pat++;
        b_cycle(0, 1, 8'h00);
        b_cycle(0, 1, 8'h00);
      end
      b_cycle(0, 1, 8'h00);
    end
    b_cycle(0, 1, 8'h00);
    b_cycle(0, 1, 8'h00);
    n_cmp++;
    if (b_empty !== 1'b1) begin
      n_err++;
      $display("FAIL t3_empty got %b want 1", b_empty);
    end
  endtask

  task automatic test_thresholds();
    a_reset();
    for (int i = 1; i <= 6; i++) begin
      a_write(8'(8'h20 + i));
      n_cmp++;
      if (a_ae !== (i <= 2) || a_af !== (i >= 6)) begin
        n_err++;
        $display("FAIL t4_flags cnt %0d got ae%b af%b want ae%b af%b",
                 i, a_ae, a_af, (i <= 2), (i >= 6));
      end
    end
    a_idle();
    a_wr_cs = 1; a_wr_en = 1; a_din = 8'h77;
    a_rd_cs = 1; a_rd_en = 1;
    step();
    a_idle();
    q.push_back(8'h77);
    exp_d = q.pop_front();
    n_cmp++;
    if (a_cnt !== 4'd6 || a_af !== 1'b1 || a_ae !== 1'b0) begin
      n_err++;
      $display("FAIL t4_rw got cnt%0d af%b ae%b want 6/1/0",
               a_cnt, a_af, a_ae);
    end
    n_cmp++;
    if (a_dout !== exp_d) begin
      n_err++;
      $display("FAIL t4_rw_data got %h want %h", a_dout, exp_d);
    end
  endtask

  task automatic c_write(input logic [7:0] d);
    c_wr_cs = 1; c_wr_en = 1; c_din = d;
    step();
    c_wr_cs = 0; c_wr_en = 0;
    q.push_back(d);
  endtask

  task automatic c_read();
    c_rd_cs = 1; c_rd_en = 1;
    step();
    c_rd_cs = 0; c_rd_en = 0;
    void'(q.pop_front());
  endtask

  task automatic test_fwft();
    q.delete();
    c_rst = 1; step(); c_rst = 0;
    n_cmp++;
    if (c_empty !== 1'b1 || c_dout !== 8'h00) begin
      n_err++;
      $display("FAIL t5_rst got %b/%h want 1/00", c_empty, c_dout);
    end
    c_write(8'h5A);
    n_cmp++;
    if (c_empty !== 1'b0 || c_dout !== 8'h5A) begin
      n_err++;
      $display("FAIL t5_fall got %b/%h want 0/5a", c_empty, c_dout);
    end
    c_read();
    n_cmp++;
    if (c_empty !== 1'b1) begin
      n_err++;
      $display("FAIL t5_pop got %b want 1", c_empty);
    end
    c_write(8'h11);
    c_write(8'h22);
    c_write(8'h33);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (c_empty !== 1'b0 || c_dout !== q[0]) begin
        n_err++;
        $display("FAIL t5_head got %b/%h want 0/%h", c_empty, c_dout, q[0]);
      end
      c_read();
    end
    n_cmp++;
    if (c_empty !== 1'b1 || c_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL t5_end got %b/%0d want 1/0", c_empty, c_cnt);
    end
  endtask

  task automatic test_mid_reset();
    a_reset();
    a_rd_cs = 0; a_rd_en = 1;
    step();
    a_idle();
    n_cmp++;
    if (a_udf !== 1'b0) begin
      n_err++;
      $display("FAIL t6_rdcs got %b want 0", a_udf);
    end
    a_rd_cs = 1; a_rd_en = 1;
    step();
    a_idle();
    n_cmp++;
    if (a_udf !== 1'b1) begin
      n_err++;
      $display("FAIL t6_udf got %b want 1", a_udf);
    end
    a_wr_cs = 1; a_wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h60 + i);
      step();
    end
    a_din = 8'h66;
    a_rst = 1;
    step();
    a_rst = 0;
    q.delete();
    n_cmp++;
    if (a_cnt !== 4'd0 || a_empty !== 1'b1 ||
        a_ovf !== 1'b0 || a_udf !== 1'b0) begin
      n_err++;
      $display("FAIL t6_rst got %0d/%b/%b/%b want 0/1/0/0",
               a_cnt, a_empty, a_ovf, a_udf);
    end
    a_din = 8'h77;
    step();
    q.push_back(8'h77);
    a_idle();
    n_cmp++;
    if (a_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL t6_post_cnt got %0d want 1", a_cnt);
    end
    a_read("t6_post_read");
    a_wr_cs = 0; a_wr_en = 1; a_din = 8'h99;
    step();
    a_idle();
    n_cmp++;
    if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin
      n_err++;
      $display("FAIL t6_wrcs got %0d/%b want 0/1", a_cnt, a_empty);
    end
    for (int i = 0; i < 8; i++) a_write(8'(8'h80 + i));
    a_wr_cs = 0; a_wr_en = 1; a_din = 8'h99;
    step();
    a_idle();
    n_cmp++;
    if (a_ovf !== 1'b0 || a_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL t6_wrcs_full got %b/%0d want 0/8", a_ovf, a_cnt);
    end
    for (int i = 0; i < 8; i++) a_read("t6_drain");
  endtask

  initial begin
    #1;
    b_rst = 1; c_rst = 1;
    step();
    b_rst = 0; c_rst = 0;
    test_reset();
    test_fill_drain();
    test_errors();
    test_wrap_npot();
    test_thresholds();
    test_fwft();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
